tick_sched: RTL and testbench
=============================

# tick_sched

Multi-channel periodic/one-shot event scheduler driven by one shared prescaled time base. A prescaler divides i_clk to a base tick; on each tick a scan FSM walks all channels through a single shared down-counter datapath, one channel per cycle, and emits one-cycle fire pulses. Sits between the system clock and slow consumers (LED blink, polling, debounce sampling), replacing per-consumer free-running dividers.

## Interface
- CLK_DIV, 50000: i_clk cycles per base tick; must be ≥ NUM_CH+2.
- NUM_CH, 4: number of channels, 2..16.
- CNT_W, 16: period/counter width.
- i_clk  in  1  system clock; all logic on posedge.
- i_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_cfg_valid  in  1  config write request.
- i_cfg_ch  in  $clog2(NUM_CH)  target channel.
- i_cfg_period  in  CNT_W  period in ticks; 0 disables the channel.
- i_cfg_oneshot  in  1  1 = fire once then deactivate; 0 = periodic.
- o_cfg_ready  out  1  config accepted when i_cfg_valid & o_cfg_ready.
- o_tick  out  1  one-cycle base tick pulse.
- o_fire  out  NUM_CH  one-cycle fire pulse per channel.
- o_active  out  NUM_CH  channel armed.
- o_busy  out  1  scan in progress.
- o_overrun  out  1  one-cycle pulse: tick arrived while o_busy.

## Operation
- Reset values: prescaler 0, FSM IDLE, all counters/periods/modes 0, o_tick/o_fire/o_active/o_busy/o_overrun 0. o_cfg_ready is combinational, so it reads 1 during reset.
- Prescaler r_pre counts 0..CLK_DIV-1 and wraps to 0. o_tick=1 exactly in the cycle r_pre==CLK_DIV-1.
- FSM states: IDLE, SCAN.
  - IDLE: o_tick=1 goes to SCAN with idx=0.
  - SCAN: process channel idx. idx==NUM_CH-1 goes to IDLE; otherwise idx+1.
- Per-channel processing, only when active:
  - count==1: set o_fire[idx] next cycle; periodic reloads count=period; one-shot clears active and count.
  - otherwise: count-1.
  - Inactive channels are skipped; the cycle is still consumed.
- Config:
  - o_cfg_ready = (state==IDLE) & ~o_tick.
  - On accept: period, mode and count=period are written; active = (period!=0).
  - Rewriting an active channel restarts its count. Period 0 deactivates immediately.
- A period of P fires on every P-th tick after the write. A one-shot with period 1 fires on the next tick.
- Ticks arriving in SCAN (parameter misuse) are dropped and pulse o_overrun. Prescaler never stalls.

## Timing
- First o_tick at cycle CLK_DIV-1 after reset release (cycle 0 = first edge with i_rst_n high).
- Tick in cycle T: SCAN occupies T+1..T+NUM_CH; channel c is processed in T+1+c; o_fire[c] is high in T+2+c only.
- o_busy high T+1..T+NUM_CH. o_active[c] for a one-shot falls in T+2+c, same cycle as its fire.
- Config stalls are at most NUM_CH+1 cycles per tick. A held request is accepted in cycle T+NUM_CH+1.
- Config accepted in cycle W takes effect from W+1; it counts from the first tick after W.
- Reset assertion mid-scan: everything returns to reset values immediately; no partial fire pulses survive.

## Test plan
Common setup for all scenarios: CLK_DIV=8, NUM_CH=4, CNT_W=8.
- Reset: all outputs 0 during reset and o_cfg_ready=1; o_tick first high at cycle 7, then every 8 cycles; o_busy high 4 cycles after each tick.
- Periodic: ch1 period=3, oneshot=0 written before the first tick -> o_fire[1] at T3+3 (T3 = third tick), then every 24 cycles; no other o_fire bits toggle.
- One-shot: ch0 period=2, oneshot=1 -> single o_fire[0] at T2+2, o_active[0] drops the same cycle, no further fires over 10 ticks.
- Config stall: assert i_cfg_valid in a tick cycle and hold it -> o_cfg_ready low for 5 cycles, accept in cycle T+5, exactly one write occurs.
- Disable/restart: ch2 period=4 running; rewrite period=0 after 2 ticks -> no fire, o_active[2]=0. Rewrite period=4 after 2 ticks -> fire at 4 ticks after the rewrite.
- Reset mid-scan: drop i_rst_n at T+2 -> o_fire/o_active/o_busy are 0 immediately; after release, first tick at cycle 7 and no channel fires.

Source files
------------

// File: rtl/tick_sched.sv
// Multi-channel periodic/one-shot tick scheduler: one prescaler, one shared
// down-counter datapath walked across all channels once per base tick.
module tick_sched #(
  parameter int CLK_DIV = 50000,
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cfg_valid,
  input  logic [$clog2(NUM_CH)-1:0] i_cfg_ch,
  input  logic [CNT_W-1:0]          i_cfg_period,
  input  logic                      i_cfg_oneshot,
  output logic                      o_cfg_ready,
  output logic                      o_tick,
  output logic [NUM_CH-1:0]         o_fire,
  output logic [NUM_CH-1:0]         o_active,
  output logic                      o_busy,
  output logic                      o_overrun
);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int PRE_W = $clog2(CLK_DIV);

  typedef enum logic {IDLE, SCAN} state_e;

  logic [PRE_W-1:0]             pre_q;
  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] per_q, per_d;
  logic [NUM_CH-1:0]            os_q, os_d;
  logic [NUM_CH-1:0]            act_q, act_d;
  logic [NUM_CH-1:0]            fire_q, fire_d;
  logic                         tick, scan_en, cfg_acc;
  logic [CNT_W-1:0]             cur_cnt;

  // Prescaler free-runs; it never stalls on scan or config traffic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          pre_q <= '0;
    else if (pre_q == PRE_W'(CLK_DIV - 1)) pre_q <= '0;
    else                                   pre_q <= pre_q + PRE_W'(1);
  end

  assign tick = (pre_q == PRE_W'(CLK_DIV - 1));

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (tick) begin
        state_d = SCAN;
        idx_d   = '0;
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_CH - 1)) state_d = IDLE;
        else                             idx_d   = idx_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    scan_en     = (state_q == SCAN);
    o_busy      = scan_en;
    o_cfg_ready = (state_q == IDLE) & ~tick;
    o_overrun   = tick & scan_en;
  end

  assign cfg_acc = i_cfg_valid & o_cfg_ready;
  assign cur_cnt = cnt_q[idx_q];

  // Shared datapath: only channel idx_q is touched per scan cycle. Config
  // writes are confined to IDLE, so they never collide with a scan update.
  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    os_d   = os_q;
    act_d  = act_q;
    fire_d = '0;
    if (scan_en && act_q[idx_q]) begin
      if (cur_cnt == CNT_W'(1)) begin
        fire_d[idx_q] = 1'b1;
        if (os_q[idx_q]) begin
          act_d[idx_q] = 1'b0;
          cnt_d[idx_q] = '0;
        end else begin
          cnt_d[idx_q] = per_q[idx_q];
        end
      end else begin
        cnt_d[idx_q] = cur_cnt - CNT_W'(1);
      end
    end
    if (cfg_acc) begin
      per_d[i_cfg_ch] = i_cfg_period;
      cnt_d[i_cfg_ch] = i_cfg_period;
      os_d[i_cfg_ch]  = i_cfg_oneshot;
      act_d[i_cfg_ch] = (i_cfg_period != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      per_q  <= '0;
      os_q   <= '0;
      act_q  <= '0;
      fire_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      os_q   <= os_d;
      act_q  <= act_d;
      fire_q <= fire_d;
    end
  end

  assign o_tick   = tick;
  assign o_fire   = fire_q;
  assign o_active = act_q;
endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched at CLK_DIV=8, NUM_CH=4, CNT_W=8.
module tb_tick_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic       cfg_oneshot = 1'b0;
  logic       cfg_ready, tick, busy, overrun;
  logic [3:0] fire, active;

  int cyc = 0, errs = 0, nchk = 0, acc = 0;

  tick_sched #(.CLK_DIV(8), .NUM_CH(4), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .i_cfg_ch(cfg_ch),
    .i_cfg_period(cfg_period), .i_cfg_oneshot(cfg_oneshot),
    .o_cfg_ready(cfg_ready), .o_tick(tick), .o_fire(fire), .o_active(active),
    .o_busy(busy), .o_overrun(overrun));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Reset with checks while held; release lands inside cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_fire", fire, 0);
    chk("rst_active", active, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Issue a config in the current cycle (ready must be high) and advance one cycle.
  task automatic cfg(input logic [1:0] ch, input logic [7:0] p, input logic os);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_period = p; cfg_oneshot = os;
    chk("cfg_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #3 rst_n = 1'b0;

    // Tick cadence and busy window
    do_reset();
    while (cyc <= 24) begin
      chk("tick", tick, (cyc % 8 == 7) ? 1 : 0);
      chk("busy", busy, (cyc > 7 && (cyc % 8) < 4) ? 1 : 0);
      step();
    end

    // Periodic ch1 period 3: third tick at 23, ch1 fires at 26, then every 24
    do_reset();
    cfg(2'd1, 8'd3, 1'b0);
    while (cyc <= 60) begin
      chk("per_fire", fire, (cyc == 26 || cyc == 50) ? 4'b0010 : 4'b0000);
      chk("per_active", active, 4'b0010);
      step();
    end

    // One-shot ch0 period 2: second tick at 15, fire and deactivate at 17
    do_reset();
    cfg(2'd0, 8'd2, 1'b1);
    while (cyc <= 90) begin
      chk("os_fire", fire, (cyc == 17) ? 4'b0001 : 4'b0000);
      chk("os_active", active, (cyc < 17) ? 4'b0001 : 4'b0000);
      step();
    end

    // Config stall: request raised in tick cycle 7, accepted in cycle 12
    do_reset();
    while (cyc < 7) step();
    chk("stall_tick", tick, 1);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_period = 8'd1; cfg_oneshot = 1'b1;
    acc = 0;
    while (cyc <= 12) begin
      chk("stall_ready", cfg_ready, (cyc == 12) ? 1 : 0);
      chk("stall_active_pre", active, 0);
      if (cfg_valid && cfg_ready) acc++;
      step();
    end
    cfg_valid = 1'b0;
    chk("stall_accepts", acc, 1);
    while (cyc <= 40) begin
      chk("stall_fire", fire, (cyc == 20) ? 4'b1000 : 4'b0000);
      chk("stall_active", active, (cyc < 20) ? 4'b1000 : 4'b0000);
      step();
    end

    // Disable after 2 ticks, then restart at cycle 60 (ticks 63,71,79,87 -> fire 91)
    do_reset();
    cfg(2'd2, 8'd4, 1'b0);
    while (cyc < 20) step();
    cfg(2'd2, 8'd0, 1'b0);
    while (cyc < 60) begin
      chk("dis_fire", fire, 0);
      chk("dis_active", active, 0);
      step();
    end
    cfg(2'd2, 8'd4, 1'b0);
    while (cyc <= 130) begin
      chk("rst_fire2", fire, (cyc == 91 || cyc == 123) ? 4'b0100 : 4'b0000);
      chk("rst_active2", active, 4'b0100);
      step();
    end

    // Reset mid-scan at T+2 (tick 7): fire[0] visible, then cleared at once
    do_reset();
    cfg(2'd0, 8'd1, 1'b0);
    cfg(2'd1, 8'd1, 1'b0);
    while (cyc < 9) step();
    chk("mid_fire_pre", fire, 4'b0001);
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_fire", fire, 0);
    chk("mid_active", active, 0);
    chk("mid_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc <= 30) begin
      chk("post_tick", tick, (cyc % 8 == 7) ? 1 : 0);
      chk("post_fire", fire, 0);
      chk("post_active", active, 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
